// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the CPU load/store path and a
//   debug/loader port. Each access is captured into registers on arbitration,
//   issued to memory for one cycle, optionally waits MEM_LAT cycles for read
//   data, and returns that data one cycle after capture.
//
// Ports
//   clk, reset                         clock, async active-low reset
//   cpu_req/we/addr/wdata              CPU request (held until done)
//   cpu_gnt/rvalid/rdata, cpu_stall    CPU response, stall for pc freeze
//   dbg_req/we/addr/wdata              debug request
//   dbg_gnt/rvalid/rdata               debug response
//   mem_read/write/addr/wdata, mem_rdata   data memory interface
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam int   CNT_W   = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    state_t            state, next_state;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              owner_q;
    logic              last_owner;
    logic [CNT_W-1:0]  cnt;
    logic              cpu_rvalid_q, dbg_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

    logic latch, win_dbg, capture, cnt_load, cnt_dec;
    logic in_issue, in_wait, cpu_done;

    // Debug wins when it is alone, or on a tie when the CPU went last.
    assign win_dbg = dbg_req & (~cpu_req | (last_owner == OWN_CPU));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        latch      = 1'b0;
        capture    = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    latch      = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    next_state = IDLE;
                end else if (MEM_LAT == 0) begin
                    capture    = 1'b1;
                    next_state = IDLE;
                end else begin
                    cnt_load   = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                // Counter starts at MEM_LAT, so the capture lands MEM_LAT
                // cycles after the ISSUE cycle.
                if (cnt == CNT_W'(1)) begin
                    capture    = 1'b1;
                    next_state = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            owner_q      <= OWN_CPU;
            last_owner   <= OWN_DBG;
            cnt          <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            if (latch) begin
                we_q    <= win_dbg ? dbg_we    : cpu_we;
                addr_q  <= win_dbg ? dbg_addr  : cpu_addr;
                wdata_q <= win_dbg ? dbg_wdata : cpu_wdata;
                owner_q <= win_dbg;
            end
            if (in_issue) last_owner <= owner_q;
            if (cnt_load)     cnt <= CNT_W'(MEM_LAT);
            else if (cnt_dec) cnt <= cnt - CNT_W'(1);
            cpu_rvalid_q <= capture & (owner_q == OWN_CPU);
            dbg_rvalid_q <= capture & (owner_q == OWN_DBG);
            if (capture && owner_q == OWN_CPU) cpu_rdata_q <= mem_rdata;
            if (capture && owner_q == OWN_DBG) dbg_rdata_q <= mem_rdata;
        end
    end

    assign in_issue  = (state == ISSUE);
    assign in_wait   = (state == WAIT);

    assign mem_write = in_issue & we_q;
    assign mem_read  = (in_issue & ~we_q) | in_wait;
    assign mem_addr  = (state != IDLE) ? addr_q  : '0;
    assign mem_wdata = (state != IDLE) ? wdata_q : '0;

    assign cpu_gnt    = in_issue & (owner_q == OWN_CPU);
    assign dbg_gnt    = in_issue & (owner_q == OWN_DBG);
    assign cpu_rvalid = cpu_rvalid_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;

    // Stall is gated by reset so every output reads 0 while reset is held,
    // even with cpu_req asserted. No mem_rdata term on this path.
    assign cpu_done  = cpu_rvalid_q | (cpu_gnt & we_q);
    assign cpu_stall = reset & cpu_req & ~cpu_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance with combinational memory ----------------
    logic        rst0;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        cpu_gnt, cpu_rvalid, cpu_stall, dbg_gnt, dbg_rvalid;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        m0_read, m0_write;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [31:0] mem0 [0:63];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(0)) u0 (
        .clk(clk), .reset(rst0),
        .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr), .cpu_wdata(c_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(d_req), .dbg_we(d_we), .dbg_addr(d_addr), .dbg_wdata(d_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_read(m0_read), .mem_write(m0_write), .mem_addr(m0_addr),
        .mem_wdata(m0_wdata), .mem_rdata(m0_rdata)
    );

    assign m0_rdata = mem0[m0_addr[7:2]];
    always @(posedge clk) if (m0_write) mem0[m0_addr[7:2]] <= m0_wdata;

    // ---------------- instance with 3-cycle memory ----------------
    logic        rst3;
    logic        e_creq, e_cwe, e_dreq, e_dwe;
    logic [31:0] e_caddr, e_cwdata, e_daddr, e_dwdata;
    logic        e_cgnt, e_crvalid, e_cstall, e_dgnt, e_drvalid;
    logic [31:0] e_crdata, e_drdata;
    logic        m3_read, m3_write;
    logic [31:0] m3_addr, m3_wdata, m3_rdata;
    logic [31:0] mem3 [0:63];
    int          rd_cnt;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u3 (
        .clk(clk), .reset(rst3),
        .cpu_req(e_creq), .cpu_we(e_cwe), .cpu_addr(e_caddr), .cpu_wdata(e_cwdata),
        .cpu_gnt(e_cgnt), .cpu_rvalid(e_crvalid), .cpu_rdata(e_crdata), .cpu_stall(e_cstall),
        .dbg_req(e_dreq), .dbg_we(e_dwe), .dbg_addr(e_daddr), .dbg_wdata(e_dwdata),
        .dbg_gnt(e_dgnt), .dbg_rvalid(e_drvalid), .dbg_rdata(e_drdata),
        .mem_read(m3_read), .mem_write(m3_write), .mem_addr(m3_addr),
        .mem_wdata(m3_wdata), .mem_rdata(m3_rdata)
    );

    // Read data is only valid once the strobe has been held 3 cycles.
    always @(posedge clk) rd_cnt <= m3_read ? rd_cnt + 1 : 0;
    assign m3_rdata = (rd_cnt >= 3) ? mem3[m3_addr[7:2]] : 32'hBAD0_BAD0;
    always @(posedge clk) if (m3_write) mem3[m3_addr[7:2]] <= m3_wdata;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] cq[$], dq[$], q3c[$], q3d[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_cmp(input string name, input logic [31:0] act, inout logic [31:0] q[$]);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected rvalid with data %h at %0t", name, act, $time);
        end else begin
            check(name, act, q.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (rst0 && cpu_rvalid) pop_cmp("cpu_rdata", cpu_rdata, cq);
        if (rst0 && dbg_rvalid) pop_cmp("dbg_rdata", dbg_rdata, dq);
        if (rst3 && e_crvalid)  pop_cmp("lat3_cpu_rdata", e_crdata, q3c);
        if (rst3 && e_drvalid)  pop_cmp("lat3_dbg_rdata", e_drdata, q3d);
        if ((m0_read && m0_write) || (cpu_gnt && dbg_gnt) ||
            (m3_read && m3_write) || (e_cgnt && e_dgnt)) begin
            errors++;
            $display("FAIL exclusivity: strobes or grants overlap at %0t", $time);
        end
    end

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        dbg;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[9];

    // One isolated access on the MEM_LAT=0 instance; request is dropped in
    // the cycle the access completes, like a CPU advancing its pc.
    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        if (v.dbg) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
            if (!v.we) dq.push_back(v.exp);
        end else begin
            c_req = 1'b1; c_we = v.we; c_addr = v.addr; c_wdata = v.wdata;
            if (!v.we) cq.push_back(v.exp);
        end
        @(negedge clk);
        check("idle_gnt", {30'd0, cpu_gnt, dbg_gnt}, 32'd0);
        check("idle_strobes", {30'd0, m0_read, m0_write}, 32'd0);
        check("idle_addr", m0_addr, 32'd0);
        if (!v.dbg) check("stall_req_cycle", {31'd0, cpu_stall}, 32'd1);
        @(negedge clk);
        check("grant", {30'd0, cpu_gnt, dbg_gnt}, v.dbg ? 32'd1 : 32'd2);
        check("strobes", {30'd0, m0_read, m0_write}, v.we ? 32'd1 : 32'd2);
        check("mem_addr", m0_addr, v.addr);
        if (v.we) check("mem_wdata", m0_wdata, v.wdata);
        if (!v.dbg) check("stall_gnt_cycle", {31'd0, cpu_stall}, v.we ? 32'd0 : 32'd1);
        if (!v.we) begin
            @(negedge clk);
            check("rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, v.dbg ? 32'd1 : 32'd2);
            if (!v.dbg) check("stall_rvalid_cycle", {31'd0, cpu_stall}, 32'd0);
        end
        c_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:8] a_cg, a_dg, a_st;
        logic [0:5] l_rd, l_st, l_rv, l_g;

        tbl[0] = '{1'b0, 1'b0, 32'h08, 32'h0,         32'h0000_1234};
        tbl[1] = '{1'b0, 1'b1, 32'h10, 32'h0000_DEAD, 32'h0};
        tbl[2] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'h0000_DEAD};
        tbl[3] = '{1'b1, 1'b1, 32'h14, 32'hCAFE_0001, 32'h0};
        tbl[4] = '{1'b1, 1'b0, 32'h14, 32'h0,         32'hCAFE_0001};
        tbl[5] = '{1'b0, 1'b0, 32'h14, 32'h0,         32'hCAFE_0001};
        tbl[6] = '{1'b1, 1'b0, 32'h08, 32'h0,         32'h0000_1234};
        tbl[7] = '{1'b0, 1'b1, 32'h00, 32'hFFFF_FFFF, 32'h0};
        tbl[8] = '{1'b0, 1'b0, 32'h00, 32'h0,         32'hFFFF_FFFF};

        for (int i = 0; i < 64; i++) begin
            mem0[i] = 32'h0;
            mem3[i] = 32'h0;
        end
        mem0[2] = 32'h0000_1234;
        mem3[2] = 32'h0000_1234;

        rst0 = 1'b0; rst3 = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h8; c_wdata = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        e_creq = 1'b0; e_cwe = 1'b0; e_caddr = 32'h0; e_cwdata = 32'h0;
        e_dreq = 1'b0; e_dwe = 1'b0; e_daddr = 32'h0; e_dwdata = 32'h0;

        // Reset state, with a CPU request pending to exercise stall gating.
        @(negedge clk);
        check("reset_ctrl", {25'd0, cpu_gnt, cpu_rvalid, cpu_stall, dbg_gnt,
                             dbg_rvalid, m0_read, m0_write}, 32'd0);
        check("reset_mem_addr", m0_addr, 32'd0);
        check("reset_cpu_rdata", cpu_rdata, 32'd0);
        c_req = 1'b0;
        @(posedge clk); #1;
        rst0 = 1'b1; rst3 = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(tbl[i]);

        // Both ports requesting loads continuously after a reset: CPU first,
        // then strict alternation; stall high while the DBG access runs.
        @(posedge clk); #1 rst0 = 1'b0;
        @(posedge clk); #1 rst0 = 1'b1;
        a_cg = 9'b010001000;
        a_dg = 9'b000100010;
        a_st = 9'b110111011;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h08;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        cq.push_back(32'h0000_1234); cq.push_back(32'h0000_1234);
        dq.push_back(32'h0000_DEAD); dq.push_back(32'h0000_DEAD);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("rr_cpu_gnt[%0d]", k), {31'd0, cpu_gnt},   {31'd0, a_cg[k]});
            check($sformatf("rr_dbg_gnt[%0d]", k), {31'd0, dbg_gnt},   {31'd0, a_dg[k]});
            check($sformatf("rr_stall[%0d]", k),   {31'd0, cpu_stall}, {31'd0, a_st[k]});
        end
        c_req = 1'b0;
        d_req = 1'b0;

        // DBG drops its request right after the grant.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h08;
        dq.push_back(32'h0000_1234);
        @(negedge clk);
        check("drop_pre_gnt", {31'd0, dbg_gnt}, 32'd0);
        @(negedge clk);
        check("drop_gnt", {31'd0, dbg_gnt}, 32'd1);
        d_req = 1'b0;
        @(negedge clk);
        check("drop_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("drop_no_regrant", {30'd0, dbg_gnt, m0_read}, 32'd0);
        end

        // MEM_LAT=3 CPU load.
        l_rd = 6'b011110;
        l_st = 6'b111110;
        l_rv = 6'b000001;
        l_g  = 6'b010000;
        @(posedge clk); #1;
        e_creq = 1'b1; e_cwe = 1'b0; e_caddr = 32'h08;
        q3c.push_back(32'h0000_1234);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("lat3_read[%0d]", k),   {31'd0, m3_read},   {31'd0, l_rd[k]});
            check($sformatf("lat3_stall[%0d]", k),  {31'd0, e_cstall},  {31'd0, l_st[k]});
            check($sformatf("lat3_rvalid[%0d]", k), {31'd0, e_crvalid}, {31'd0, l_rv[k]});
            check($sformatf("lat3_gnt[%0d]", k),    {31'd0, e_cgnt},    {31'd0, l_g[k]});
        end
        e_creq = 1'b0;

        // Reset while waiting on memory: the access is abandoned, and the
        // CPU wins the first tie after release even though it went last.
        @(posedge clk); #1;
        e_creq = 1'b1; e_caddr = 32'h08;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("wait_reached", {31'd0, m3_read}, 32'd1);
        e_dreq = 1'b1; e_dwe = 1'b0; e_daddr = 32'h08;
        rst3 = 1'b0;
        #1;
        check("midreset_ctrl", {25'd0, e_cgnt, e_crvalid, e_cstall, e_dgnt,
                                e_drvalid, m3_read, m3_write}, 32'd0);
        check("midreset_addr", m3_addr, 32'd0);
        check("midreset_wdata", m3_wdata, 32'd0);
        check("midreset_cpu_rdata", e_crdata, 32'd0);
        @(posedge clk);
        @(posedge clk); #1 rst3 = 1'b1;
        q3c.push_back(32'h0000_1234);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("rel_cpu_gnt[%0d]", k), {31'd0, e_cgnt},    {31'd0, l_g[k]});
            check($sformatf("rel_dbg_gnt[%0d]", k), {31'd0, e_dgnt},    32'd0);
            check($sformatf("rel_rvalid[%0d]", k),  {30'd0, e_crvalid, e_drvalid},
                  {30'd0, l_rv[k], 1'b0});
        end
        e_creq = 1'b0;
        e_dreq = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("cpu_queue_empty", cq.size(), 32'd0);
        check("dbg_queue_empty", dq.size(), 32'd0);
        check("lat3_queue_empty", q3c.size() + q3d.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
